branch_predictor: RTL

Gshare direction predictor plus direct-mapped branch target buffer for the fetch stage. Each cycle it supplies the prediction signals that the execute stage carries down the pipe: taken, PHT index, BTB hit and BTB target. It also supplies the predicted next PC. It is trained by the execute stage's resolution outputs: update enable, actual taken, resolved PC and actual target.

---
 rtl/bp_pkg.sv | 31 +++
 rtl/bp_btb.sv | 65 ++++++
 rtl/branch_predictor.sv | 88 ++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and defaults for the gshare branch predictor.
//   counter_t  : 2-bit saturating direction counter encoding
//   PHT_IDX_W  : default PHT index width (256 counters)
//   BTB_IDX_W  : default BTB index width (64 entries)
//   sat_update : next value of a counter given the resolved direction
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } counter_t;

    localparam int unsigned PHT_IDX_W = 8;
    localparam int unsigned BTB_IDX_W = 6;

    function automatic counter_t sat_update(input counter_t c, input logic taken);
        counter_t n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = WNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (clears valid bits only)
//   i_lookup_pc    : PC to look up (combinational read from registered state)
//   o_hit          : valid entry with matching tag
//   o_target       : stored target on hit, 0 on miss
//   i_wr_en        : write strobe (taken resolution)
//   i_wr_pc        : PC selecting index/tag of the entry to overwrite
//   i_wr_target    : target to store
module bp_btb
    import bp_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 1 << BTB_IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_lookup_pc,
    output logic        o_hit,
    output logic [31:0] o_target,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_pc,
    input  logic [31:0] i_wr_target
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
    logic [31:0]            r_target [BTB_ENTRIES];

    logic [IDX_W-1:0] w_rd_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic [IDX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0] w_wr_tag;
    logic             w_unused_lsbs;

    assign w_rd_idx = i_lookup_pc[IDX_W+1:2];
    assign w_rd_tag = i_lookup_pc[31:IDX_W+2];
    assign w_wr_idx = i_wr_pc[IDX_W+1:2];
    assign w_wr_tag = i_wr_pc[31:IDX_W+2];

    // Instructions are word aligned; the byte offset never participates.
    assign w_unused_lsbs = ^{i_lookup_pc[1:0], i_wr_pc[1:0]};

    assign o_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_target = o_hit ? r_target[w_rd_idx] : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag/target need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[w_wr_idx]    <= w_wr_tag;
            r_target[w_wr_idx] <= i_wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor with direct-mapped BTB for the fetch stage.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   F_PC              : fetch PC being predicted
//   F_pred_taken      : predicted direction (PHT counter MSB)
//   F_pht_idx         : PHT index used (PC bits xor global history)
//   F_btb_hit         : BTB hit for F_PC
//   F_btb_target      : BTB target, 0 on miss
//   F_pred_next_pc    : BTB target when predicted taken and hit, else F_PC+4
//   ex_update_en      : resolved branch/JAL/JALR this cycle
//   ex_actual_taken   : resolved direction
//   ex_pc             : PC of the resolved instruction
//   ex_actual_target  : resolved target
//   ex_pht_idx        : PHT index the instruction was predicted with
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PHT_ENTRIES = 1 << PHT_IDX_W,
    parameter int unsigned BTB_ENTRIES = 1 << BTB_IDX_W,
    // Must equal log2(PHT_ENTRIES); the history is xor-ed across the full index.
    parameter int unsigned GHR_BITS    = $clog2(PHT_ENTRIES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    F_PC,
    output logic                           F_pred_taken,
    output logic [$clog2(PHT_ENTRIES)-1:0] F_pht_idx,
    output logic                           F_btb_hit,
    output logic [31:0]                    F_btb_target,
    output logic [31:0]                    F_pred_next_pc,
    input  logic                           ex_update_en,
    input  logic                           ex_actual_taken,
    input  logic [31:0]                    ex_pc,
    input  logic [31:0]                    ex_actual_target,
    input  logic [$clog2(PHT_ENTRIES)-1:0] ex_pht_idx
);

    localparam int unsigned IDX_W = $clog2(PHT_ENTRIES);

    counter_t            r_pht [PHT_ENTRIES];
    logic [GHR_BITS-1:0] r_ghr;

    logic [IDX_W-1:0] w_idx;
    logic             w_btb_hit;
    logic [31:0]      w_btb_target;
    logic [31:0]      w_pc_plus4;

    // Lookup reads registered state only; an update in the same cycle is not bypassed.
    assign w_idx        = F_PC[IDX_W+1:2] ^ r_ghr;
    assign F_pht_idx    = w_idx;
    assign F_pred_taken = r_pht[w_idx][1];

    // Training writes the index the instruction was predicted with, so the
    // history in effect at fetch time is honoured even though r_ghr has moved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
                r_pht[IDX_W'(i)] <= WNT;
            end
            r_ghr <= '0;
        end else if (ex_update_en) begin
            r_pht[ex_pht_idx] <= sat_update(r_pht[ex_pht_idx], ex_actual_taken);
            r_ghr             <= {r_ghr[GHR_BITS-2:0], ex_actual_taken};
        end
    end

    bp_btb #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .i_lookup_pc (F_PC),
        .o_hit       (w_btb_hit),
        .o_target    (w_btb_target),
        .i_wr_en     (ex_update_en & ex_actual_taken),
        .i_wr_pc     (ex_pc),
        .i_wr_target (ex_actual_target)
    );

    assign F_btb_hit    = w_btb_hit;
    assign F_btb_target = w_btb_target;

    // Wraps modulo 2^32 by construction.
    assign w_pc_plus4     = F_PC + 32'd4;
    // Predicted taken without a BTB hit falls through to PC+4.
    assign F_pred_next_pc = (F_pred_taken & w_btb_hit) ? w_btb_target : w_pc_plus4;

endmodule
